// File: rtl/ram_arbiter_2x16_pkg.sv
// ram_ctrl_pkg: shared sizing, FSM state encoding and read-tag layout for the
// two-client RAM arbiter/sequencer and its RAM model.
package ram_ctrl_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;  // 2**ADDR_W, also the init-sweep length

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  // Tracks one issued command until its read data is back from the RAM.
  typedef struct packed {
    logic is_read;
    logic client_id;
  } tag_t;
endpackage

// File: rtl/ram_arbiter_2x16_if.sv
// Bus interfaces for the arbiter.
//   ram_req_if : one client command port. master = client, slave = arbiter.
//     valid/we/addr/wdata : command (held stable by the client until ready)
//     ready               : command accepted this cycle
//     rvalid/rdata        : read return (rdata meaningful only with rvalid)
//   ram_port_if : single-port synchronous RAM port. master = arbiter, slave = RAM.
//     we/re/addr/din : command, dout : read data (registered in the RAM)
interface ram_req_if;
  import ram_ctrl_pkg::*;
  logic              valid;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, we, addr, wdata, input  ready, rvalid, rdata);
  modport slave  (input  valid, we, addr, wdata, output ready, rvalid, rdata);
endinterface

interface ram_port_if;
  import ram_ctrl_pkg::*;
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (output we, re, addr, din, input  dout);
  modport slave  (input  we, re, addr, din, output dout);
endinterface

// File: rtl/ram_arbiter_2x16_rr_arb2.sv
// rr_arb2: two-way round-robin grant with its last-grant pointer.
//   clk, rst  : clock, synchronous active-high reset
//   i_en      : grants allowed this cycle
//   i_valid   : request vector {client1, client0}
//   o_grant   : one-hot grant, combinational from i_valid and the pointer
//   o_gnt_id  : index of the granted client (meaningful when |o_grant)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant,
  output logic       o_gnt_id
);
  logic       r_last;  // client granted most recently
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (i_en) begin
      // On contention favour whichever client did not win last time.
      if (&i_valid) w_gnt = r_last ? 2'b01 : 2'b10;
      else          w_gnt = i_valid;
    end
  end

  // Pointer resets to "client 1 last" so client 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)         r_last <= 1'b1;
    else if (|w_gnt) r_last <= w_gnt[1];
  end

  assign o_grant  = w_gnt;
  assign o_gnt_id = w_gnt[1];
endmodule

// File: rtl/sync_ram_16x16.sv
// sync_ram_16x16: 16x16 single-port synchronous RAM. Write and read are both
// sampled on the rising edge; dout is registered, so data for a read issued
// on one edge is visible the cycle after that edge. No reset on the array.
//   clk : clock
//   ram : ram_port_if.slave (we, re, addr, din in; dout out)
module sync_ram_16x16
  import ram_ctrl_pkg::*;
(
  input logic       clk,
  ram_port_if.slave ram
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (ram.we) r_mem[ram.addr] <= ram.din;
    if (ram.re) r_dout <= r_mem[ram.addr];
  end

  assign ram.dout = r_dout;
endmodule

// File: rtl/ram_arbiter_2x16.sv
// ram_arbiter_2x16: zero-fills the RAM after reset, then serialises read/write
// commands from two clients into the RAM (one per cycle, round-robin on
// contention) and returns read data to the issuing client two cycles after
// acceptance.
//   clk, rst  : clock, synchronous active-high reset
//   req0/req1 : ram_req_if.slave client ports
//   ram       : ram_port_if.master toward sync_ram_16x16
//   init_done : high once the zero-fill sweep has been issued
module ram_arbiter_2x16
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  ram_req_if.slave   req0,
  ram_req_if.slave   req1,
  ram_port_if.master ram,
  output logic       init_done
);
  state_e            r_state, w_state_nxt;
  logic [ADDR_W:0]   r_cnt;        // one spare bit so DEPTH-1 decodes cleanly
  logic              r_ram_we, r_ram_re;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_din;
  logic              r_init_done;
  tag_t [2:1]        r_tag;        // [1]: command on the RAM bus, [2]: data on dout

  logic [1:0]        w_gnt;
  logic              w_gnt_id;
  logic              w_init_last;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Grants are suppressed during reset so nothing is accepted that the
  // pipeline flush would then silently drop.
  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_en     ((r_state == ST_RUN) && !rst),
    .i_valid  ({req1.valid, req0.valid}),
    .o_grant  (w_gnt),
    .o_gnt_id (w_gnt_id)
  );

  assign w_sel_we    = w_gnt_id ? req1.we    : req0.we;
  assign w_sel_addr  = w_gnt_id ? req1.addr  : req0.addr;
  assign w_sel_wdata = w_gnt_id ? req1.wdata : req0.wdata;

  assign w_init_last = (r_state == ST_INIT) && (r_cnt == (ADDR_W+1)'(DEPTH-1));

  always_comb begin
    w_state_nxt = r_state;
    if (w_init_last) w_state_nxt = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_ram_we    <= 1'b0;
      r_ram_re    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
      r_init_done <= 1'b0;
      r_tag       <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_tag[2] <= r_tag[1];
      if (r_state == ST_INIT) begin
        r_ram_we   <= 1'b1;
        r_ram_re   <= 1'b0;
        r_ram_addr <= r_cnt[ADDR_W-1:0];
        r_ram_din  <= '0;
        r_cnt      <= r_cnt + 1'b1;
        r_tag[1]   <= '0;
        if (w_init_last) r_init_done <= 1'b1;
      end else begin
        // Idle cycles leave addr/din as they were; only the strobes drop.
        r_ram_we <= (|w_gnt) &&  w_sel_we;
        r_ram_re <= (|w_gnt) && !w_sel_we;
        if (|w_gnt) begin
          r_ram_addr <= w_sel_addr;
          r_ram_din  <= w_sel_wdata;
        end
        r_tag[1] <= '{is_read: (|w_gnt) && !w_sel_we, client_id: w_gnt_id};
      end
    end
  end

  assign ram.we    = r_ram_we;
  assign ram.re    = r_ram_re;
  assign ram.addr  = r_ram_addr;
  assign ram.din   = r_ram_din;
  assign init_done = r_init_done;

  assign req0.ready  = w_gnt[0];
  assign req1.ready  = w_gnt[1];
  assign req0.rvalid = r_tag[2].is_read && !r_tag[2].client_id;
  assign req1.rvalid = r_tag[2].is_read &&  r_tag[2].client_id;
  assign req0.rdata  = ram.dout;
  assign req1.rdata  = ram.dout;
endmodule
